// File: rtl/udma_uart_tx_buffer.sv
// -----------------------------------------------------------------------------
// udma_uart_tx_buffer
//   TX elastic buffer between the uDMA TX channel and the UART TX serializer.
//   It absorbs uDMA bursts so that the serializer always has a byte pending.
//   It reports the fill level and a low-watermark event for refill and IRQ
//   logic, and it supports a software flush.
//
//   Optional feature: define UDMA_UART_TX_BUF_GAP_EN to insert cfg_gap_i idle
//   cycles on the output after every pop.
//
// Ports
//   clk_i        system clock
//   rst_i        synchronous active-high reset
//   cfg_flush_i  one-cycle pulse that discards all stored bytes
//   cfg_thr_i    low-watermark threshold, 0..DEPTH
//   cfg_gap_i    idle cycles after each pop (only with UDMA_UART_TX_BUF_GAP_EN)
//   in_data_i    byte from the uDMA TX channel
//   in_valid_i   in_data_i is valid
//   in_ready_o   the buffer accepts in_data_i this cycle
//   out_data_o   byte to the serializer
//   out_valid_o  out_data_o is valid
//   out_ready_i  the serializer accepts the byte
//   level_o      stored byte count, 0..DEPTH
//   empty_o      level_o == 0
//   full_o       level_o == DEPTH
//   thr_evt_o    one-cycle pulse when the level crosses below cfg_thr_i
// -----------------------------------------------------------------------------
module udma_uart_tx_buffer #(
    parameter  int unsigned DEPTH = 8,
    localparam int unsigned LW    = $clog2(DEPTH) + 1
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          cfg_flush_i,
    input  logic [LW-1:0] cfg_thr_i,
`ifdef UDMA_UART_TX_BUF_GAP_EN
    input  logic [7:0]    cfg_gap_i,
`endif
    input  logic [7:0]    in_data_i,
    input  logic          in_valid_i,
    output logic          in_ready_o,
    output logic [7:0]    out_data_o,
    output logic          out_valid_o,
    input  logic          out_ready_i,
    output logic [LW-1:0] level_o,
    output logic          empty_o,
    output logic          full_o,
    output logic          thr_evt_o
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [LW-1:0] level;
    logic [LW-1:0] level_next;
    logic          push;
    logic          pop;
    logic          gap_open;

    assign empty_o     = (level == '0);
    assign full_o      = (level == LW'(DEPTH));
    assign in_ready_o  = !full_o && !cfg_flush_i;
    assign out_valid_o = !empty_o && gap_open;
    assign push        = in_valid_i && in_ready_o;
    assign pop         = out_valid_o && out_ready_i;
    assign out_data_o  = mem[rd_ptr];
    assign level_o     = level;

    always_comb begin
        level_next = level;
        if (cfg_flush_i) begin
            level_next = '0;
        end else if (push && !pop) begin
            level_next = level + LW'(1);
        end else if (pop && !push) begin
            level_next = level - LW'(1);
        end
    end

    // Storage is intentionally not reset.
    always_ff @(posedge clk_i) begin
        if (push) begin
            mem[wr_ptr] <= in_data_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            level     <= '0;
            thr_evt_o <= 1'b0;
        end else begin
            if (cfg_flush_i) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
            end else begin
                if (push) begin
                    wr_ptr <= wr_ptr + AW'(1);
                end
                if (pop) begin
                    rd_ptr <= rd_ptr + AW'(1);
                end
            end
            level     <= level_next;
            // With a zero threshold level_next < 0 is impossible, so no pulse.
            thr_evt_o <= (level >= cfg_thr_i) && (level_next < cfg_thr_i);
        end
    end

`ifdef UDMA_UART_TX_BUF_GAP_EN
    typedef enum logic {
        READY,
        GAP
    } state_t;

    state_t     state;
    state_t     state_next;
    logic [7:0] gap_cnt;
    logic [7:0] gap_cnt_next;

    always_ff @(posedge clk_i) begin
        if (rst_i || cfg_flush_i) begin
            state   <= READY;
            gap_cnt <= '0;
        end else begin
            state   <= state_next;
            gap_cnt <= gap_cnt_next;
        end
    end

    always_comb begin
        state_next   = state;
        gap_cnt_next = gap_cnt;
        case (state)
            READY: begin
                if (pop && (cfg_gap_i != '0)) begin
                    state_next   = GAP;
                    gap_cnt_next = cfg_gap_i;
                end
            end
            GAP: begin
                gap_cnt_next = gap_cnt - 8'd1;
                if (gap_cnt == 8'd1) begin
                    state_next = READY;
                end
            end
            default: begin
                state_next   = READY;
                gap_cnt_next = '0;
            end
        endcase
    end

    assign gap_open = (state == READY);
`else
    assign gap_open = 1'b1;
`endif

endmodule

// File: tb/tb_udma_uart_tx_buffer.sv
module tb_udma_uart_tx_buffer;

    localparam int DEPTH = 8;
    localparam int LW    = $clog2(DEPTH) + 1;

    logic          clk;
    logic          rst;
    logic          cfg_flush;
    logic [LW-1:0] cfg_thr;
    logic [7:0]    cfg_gap;
    logic [7:0]    in_data;
    logic          in_valid;
    logic          in_ready;
    logic [7:0]    out_data;
    logic          out_valid;
    logic          out_ready;
    logic [LW-1:0] level;
    logic          empty;
    logic          full;
    logic          thr_evt;

    udma_uart_tx_buffer #(.DEPTH(DEPTH)) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .cfg_flush_i (cfg_flush),
        .cfg_thr_i   (cfg_thr),
`ifdef UDMA_UART_TX_BUF_GAP_EN
        .cfg_gap_i   (cfg_gap),
`endif
        .in_data_i   (in_data),
        .in_valid_i  (in_valid),
        .in_ready_o  (in_ready),
        .out_data_o  (out_data),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
        .level_o     (level),
        .empty_o     (empty),
        .full_o      (full),
        .thr_evt_o   (thr_evt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_chk  = 0;
    int n_fail = 0;

    // Reference model state
    int         m_level = 0;
    bit         m_evt   = 1'b0;
    int         m_gap   = 0;
    logic [7:0] sb[$];

    typedef struct {
        bit         fl;
        int         th;
        bit         v;
        logic [7:0] d;
        bit         r;
        int         lvl;
        bit         evt;
    } vec_t;

    vec_t tbl[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        cfg_flush = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst     = 1'b0;
        m_level = 0;
        m_evt   = 1'b0;
        m_gap   = 0;
        sb.delete();
        chk("rst_level", 32'(level), 0);
        chk("rst_empty", 32'(empty), 1);
        chk("rst_full", 32'(full), 0);
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_thr_evt", 32'(thr_evt), 0);
        chk("rst_in_ready", 32'(in_ready), 1);
    endtask

    // One clock cycle: drive, check outputs against the model, then advance it.
    task automatic cyc(input bit fl, input int th, input bit v, input logic [7:0] d, input bit r);
        bit exp_valid;
        bit m_pop;
        bit m_push;
        int nl;
        cfg_flush = fl;
        cfg_thr   = LW'(th);
        in_valid  = v;
        in_data   = d;
        out_ready = r;
        @(negedge clk);
        exp_valid = (m_level > 0) && (m_gap == 0);
        m_pop     = exp_valid && r;
        m_push    = v && (m_level < DEPTH) && !fl;
        chk("out_valid", 32'(out_valid), 32'(exp_valid));
        chk("in_ready", 32'(in_ready), 32'((m_level < DEPTH) && !fl));
        chk("level", 32'(level), 32'(m_level));
        chk("empty", 32'(empty), 32'(m_level == 0));
        chk("full", 32'(full), 32'(m_level == DEPTH));
        chk("thr_evt", 32'(thr_evt), 32'(m_evt));
        if (m_pop) begin
            if (sb.size() == 0) chk("sb_underflow", 1, 0);
            else chk("out_data", 32'(out_data), 32'(sb[0]));
        end
        @(posedge clk);
        if (fl) nl = 0;
        else nl = m_level + int'(m_push) - int'(m_pop);
        m_evt = (m_level >= th) && (nl < th);
        if (fl) begin
            sb.delete();
            m_gap = 0;
        end else begin
            if (m_pop && sb.size() > 0) void'(sb.pop_front());
            if (m_push) sb.push_back(d);
            if (m_pop && cfg_gap != 0) m_gap = int'(cfg_gap);
            else if (m_gap > 0) m_gap--;
        end
        m_level = nl;
        #1;
    endtask

    initial begin
        rst       = 1'b1;
        cfg_flush = 1'b0;
        cfg_thr   = '0;
        cfg_gap   = '0;
        in_data   = '0;
        in_valid  = 1'b0;
        out_ready = 1'b0;

        // {flush, thr, valid, data, ready, level after, thr_evt after}
        tbl.push_back('{0, 0, 1, 8'h55, 0, 1, 0});
        tbl.push_back('{0, 0, 0, 8'h00, 1, 0, 0});
        tbl.push_back('{0, 3, 1, 8'hA1, 0, 1, 0});
        tbl.push_back('{0, 3, 1, 8'hA2, 0, 2, 0});
        tbl.push_back('{0, 3, 1, 8'hA3, 0, 3, 0});
        tbl.push_back('{0, 3, 0, 8'h00, 1, 2, 1});
        tbl.push_back('{0, 3, 0, 8'h00, 0, 2, 0});
        tbl.push_back('{0, 3, 1, 8'hA4, 0, 3, 0});
        tbl.push_back('{0, 3, 0, 8'h00, 0, 3, 0});
        tbl.push_back('{0, 3, 1, 8'hB1, 0, 4, 0});
        tbl.push_back('{0, 3, 1, 8'hB2, 0, 5, 0});
        tbl.push_back('{1, 3, 1, 8'hEE, 0, 0, 1});
        tbl.push_back('{0, 3, 1, 8'hC1, 0, 1, 0});
        tbl.push_back('{0, 3, 0, 8'h00, 0, 1, 0});
        tbl.push_back('{1, 1, 0, 8'h00, 1, 0, 1});
        tbl.push_back('{1, 1, 0, 8'h00, 0, 0, 0});
        tbl.push_back('{0, 0, 1, 8'hD1, 0, 1, 0});
        tbl.push_back('{0, 0, 0, 8'h00, 1, 0, 0});

        do_reset();
        foreach (tbl[i]) begin
            cyc(tbl[i].fl, tbl[i].th, tbl[i].v, tbl[i].d, tbl[i].r);
            chk($sformatf("vec%0d_level", i), 32'(level), 32'(tbl[i].lvl));
            chk($sformatf("vec%0d_thr_evt", i), 32'(thr_evt), 32'(tbl[i].evt));
        end

        // Fill past DEPTH, then drain with the threshold at DEPTH.
        do_reset();
        for (int i = 0; i <= DEPTH; i++) cyc(0, 0, 1, 8'(i), 0);
        chk("fill_full", 32'(full), 1);
        chk("fill_in_ready", 32'(in_ready), 0);
        chk("fill_level", 32'(level), DEPTH);
        cyc(0, DEPTH, 0, 8'h00, 1);
        chk("thr_depth_evt", 32'(thr_evt), 1);
        cyc(0, DEPTH, 1, 8'h77, 1);
        cyc(0, 0, 1, 8'h78, 0);
        for (int i = 0; i < DEPTH; i++) cyc(0, 0, 0, 8'h00, 1);
        chk("drain_empty", 32'(empty), 1);

        // Simultaneous push and pop at level 4 across pointer wrap.
        do_reset();
        for (int i = 0; i < 4; i++) cyc(0, 0, 1, 8'h20 + 8'(i), 0);
        for (int i = 0; i < 12; i++) cyc(0, 0, 1, 8'h30 + 8'(i), 1);
        chk("steady_level", 32'(level), 4);
        for (int i = 0; i < 4; i++) cyc(0, 0, 0, 8'h00, 1);

        // Reset mid-transfer must not pulse thr_evt.
        for (int i = 0; i < 5; i++) cyc(0, 3, 1, 8'h40 + 8'(i), 0);
        cfg_thr = LW'(3);
        do_reset();
        cyc(0, 3, 0, 8'h00, 0);

`ifdef UDMA_UART_TX_BUF_GAP_EN
        cfg_gap = 8'd3;
        cyc(0, 0, 1, 8'h61, 0);
        cyc(0, 0, 1, 8'h62, 0);
        for (int i = 0; i < 8; i++) cyc(0, 0, 0, 8'h00, 1);
        cfg_gap = 8'd0;
        cyc(0, 0, 1, 8'h63, 0);
        cyc(0, 0, 1, 8'h64, 0);
        for (int i = 0; i < 3; i++) cyc(0, 0, 0, 8'h00, 1);
`endif

        // Random traffic against the model.
        do_reset();
        for (int i = 0; i < 400; i++) begin
`ifdef UDMA_UART_TX_BUF_GAP_EN
            cfg_gap = 8'($urandom_range(0, 2));
`endif
            cyc($urandom_range(0, 24) == 0, int'($urandom_range(0, DEPTH)),
                1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 1)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
